// File: rtl/clock_monitor_pkg.sv
// Shared types and default constants for the clock monitor.
package clock_monitor_pkg;

  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_EXP_TICKS = 10;
  localparam int unsigned DEF_TOL       = 1;
  localparam int unsigned DEF_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } mon_state_t;

  // Debug view: FSM state plus the synchronized level of the monitored clock.
  typedef struct packed {
    mon_state_t state;
    logic       mon_level;
  } dbg_t;

endpackage

// File: rtl/clock_monitor_edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by an edge
// register. rise/fall are single-cycle pulses in the CLOCK domain.
module edge_sync (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and previous-level register for edge detection.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/clock_monitor.sv
// Clock monitor: measures high/low phases of MON_CLK in CLOCK cycles,
// publishes one result per MON_CLK period, flags period errors and a stopped
// clock. Optional duty-cycle check is built when CLOCK_MONITOR_DUTY_CHECK_EN
// is defined; otherwise DUTY_ERR is tied low.
//
// Handshake: PERIOD_VALID is a one-cycle qualifier with no back-pressure.
// HIGH_TICKS, LOW_TICKS, PERIOD_ERR and DUTY_ERR are valid in the cycle it is
// high and hold their values until the next pulse.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned EXP_TICKS = DEF_EXP_TICKS,
  parameter int unsigned TOL       = DEF_TOL,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             MON_CLK,
  output logic [CNT_W-1:0] HIGH_TICKS,
  output logic [CNT_W-1:0] LOW_TICKS,
  output logic             PERIOD_VALID,
  output logic             PERIOD_ERR,
  output logic             DUTY_ERR,
  output logic             RUNNING,
  output logic             STOPPED,
  output dbg_t             DBG
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W+1:0] EXP_W     = (CNT_W+2)'(EXP_TICKS);
  localparam logic [CNT_W+1:0] TOL_W     = (CNT_W+2)'(TOL);

  logic             mon_level;
  logic             rise;
  logic             fall;
  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_q;
  logic             do_timeout;
  logic             do_publish;
  logic             do_latch_hi;
  logic [CNT_W:0]   period_sum;
  logic [CNT_W+1:0] sum_w;
  logic             period_err_d;
  logic             duty_err_d;

  edge_sync u_edge_sync (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .d_async (MON_CLK),
    .level   (mon_level),
    .rise    (rise),
    .fall    (fall)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Period of the phase pair being published (hi_q + low count), no wrap.
  assign period_sum   = {1'b0, hi_q} + {1'b0, cnt_q};
  assign sum_w        = {1'b0, period_sum};
  assign period_err_d = (sum_w > EXP_W + TOL_W) || (sum_w + TOL_W < EXP_W);

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
  logic [CNT_W-1:0] duty_diff;
  assign duty_diff  = (hi_q >= cnt_q) ? (hi_q - cnt_q) : (cnt_q - hi_q);
  assign duty_err_d = (duty_diff > TOL_C);
`else
  assign duty_err_d = 1'b0;
`endif

  // Next-state, counter and action decode; an edge takes priority over timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    do_timeout  = 1'b0;
    do_publish  = 1'b0;
    do_latch_hi = 1'b0;
    if (!ENABLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_d = MEAS_HIGH;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == TIMEOUT_C) begin
            do_timeout = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            state_d     = MEAS_LOW;
            do_latch_hi = 1'b1;
            cnt_d       = CNT_W'(1);
          end else if (cnt_q == TIMEOUT_C) begin
            state_d    = WAIT_RISE;
            do_timeout = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            state_d    = MEAS_HIGH;
            do_publish = 1'b1;
            cnt_d      = CNT_W'(1);
          end else if (cnt_q == TIMEOUT_C) begin
            state_d    = WAIT_RISE;
            do_timeout = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and result/status registers.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      HIGH_TICKS   <= '0;
      LOW_TICKS    <= '0;
      PERIOD_VALID <= 1'b0;
      PERIOD_ERR   <= 1'b0;
      DUTY_ERR     <= 1'b0;
      RUNNING      <= 1'b0;
      STOPPED      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      PERIOD_VALID <= do_publish;
      if (do_latch_hi) begin
        hi_q <= cnt_q;
      end
      if (do_publish) begin
        HIGH_TICKS <= hi_q;
        LOW_TICKS  <= cnt_q;
        PERIOD_ERR <= period_err_d;
        DUTY_ERR   <= duty_err_d;
        RUNNING    <= 1'b1;
      end
      if (do_timeout) begin
        STOPPED <= 1'b1;
        RUNNING <= 1'b0;
      end else if (rise) begin
        STOPPED <= 1'b0;
      end
      if (!ENABLE) begin
        RUNNING <= 1'b0;
        STOPPED <= 1'b0;
      end
    end
  end

  assign DBG = '{state: state_q, mon_level: mon_level};

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor with default parameters
// (CNT_W=16, EXP_TICKS=10, TOL=1, TIMEOUT=64).
module tb_clock_monitor;
  import clock_monitor_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        mon_clk;
  logic [15:0] high_ticks;
  logic [15:0] low_ticks;
  logic        period_valid;
  logic        period_err;
  logic        duty_err;
  logic        running;
  logic        stopped;
  dbg_t        dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pv_count = 0;
  int last_pv_cyc = 0;
  int pv_gap = 0;

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  clock_monitor dut (
    .CLOCK        (clk),
    .RESET_N      (rst_n),
    .ENABLE       (enable),
    .MON_CLK      (mon_clk),
    .HIGH_TICKS   (high_ticks),
    .LOW_TICKS    (low_ticks),
    .PERIOD_VALID (period_valid),
    .PERIOD_ERR   (period_err),
    .DUTY_ERR     (duty_err),
    .RUNNING      (running),
    .STOPPED      (stopped),
    .DBG          (dbg)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Records PERIOD_VALID pulses and the spacing between the last two.
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      pv_gap      = cyc - last_pv_cyc;
      last_pv_cyc = cyc;
      pv_count    = pv_count + 1;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b1;
    mon_clk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic mon_periods(input int hi, input int lo, input int n);
    repeat (n) begin
      mon_clk = 1'b1;
      tick(hi);
      mon_clk = 1'b0;
      tick(lo);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    enable  = 1'b1;
    mon_clk = 1'b0;
    tick(3);
    checks++;
    if ({high_ticks, low_ticks} !== 32'd0) begin
      errors++;
      $display("FAIL reset_ticks: got %0d/%0d want 0/0", high_ticks, low_ticks);
    end
    checks++;
    if ({period_valid, period_err, duty_err, running, stopped} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {period_valid, period_err, duty_err, running, stopped});
    end
    checks++;
    if (dbg.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dbg.state, IDLE);
    end
  endtask

  task automatic test_nominal();
    int base;
    do_reset();
    base = pv_count;
    mon_periods(5, 5, 4);
    mon_clk = 1'b1;
    tick(5);
    checks++;
    if (pv_count - base !== 4) begin
      errors++;
      $display("FAIL nominal_count: got %0d want 4", pv_count - base);
    end
    checks++;
    if (pv_gap !== 10) begin
      errors++;
      $display("FAIL nominal_gap: got %0d want 10", pv_gap);
    end
    checks++;
    if (high_ticks !== 16'd5 || low_ticks !== 16'd5) begin
      errors++;
      $display("FAIL nominal_ticks: got %0d/%0d want 5/5", high_ticks, low_ticks);
    end
    checks++;
    if ({period_err, duty_err, running, stopped} !== 4'b0010) begin
      errors++;
      $display("FAIL nominal_flags: got %b want 0010",
               {period_err, duty_err, running, stopped});
    end
  endtask

  task automatic test_period_err();
    do_reset();
    mon_periods(6, 6, 3);
    mon_clk = 1'b1;
    tick(5);
    checks++;
    if (high_ticks !== 16'd6 || low_ticks !== 16'd6) begin
      errors++;
      $display("FAIL perr_ticks: got %0d/%0d want 6/6", high_ticks, low_ticks);
    end
    checks++;
    if (period_err !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL perr_flags: got err=%b run=%b want 1/1", period_err, running);
    end
    checks++;
    if (pv_gap !== 12) begin
      errors++;
      $display("FAIL perr_gap: got %0d want 12", pv_gap);
    end
  endtask

  task automatic test_duty();
    do_reset();
    mon_periods(3, 7, 3);
    mon_clk = 1'b1;
    tick(5);
    checks++;
    if (high_ticks !== 16'd3 || low_ticks !== 16'd7) begin
      errors++;
      $display("FAIL duty_ticks: got %0d/%0d want 3/7", high_ticks, low_ticks);
    end
    checks++;
    if (period_err !== 1'b0 || duty_err !== DUTY_ON) begin
      errors++;
      $display("FAIL duty_flags: got perr=%b duty=%b want 0/%b", period_err, duty_err, DUTY_ON);
    end
  endtask

  // Boundary table around EXP_TICKS +/- TOL.
  task automatic test_tolerance();
    int hi_t[4]   = '{6, 4, 4, 7};
    int lo_t[4]   = '{5, 5, 4, 5};
    bit perr_t[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit duty_t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      mon_periods(hi_t[i], lo_t[i], 2);
      mon_clk = 1'b1;
      tick(5);
      checks++;
      if (high_ticks !== 16'(hi_t[i]) || low_ticks !== 16'(lo_t[i])) begin
        errors++;
        $display("FAIL tol_ticks[%0d]: got %0d/%0d want %0d/%0d",
                 i, high_ticks, low_ticks, hi_t[i], lo_t[i]);
      end
      checks++;
      if (period_err !== perr_t[i] || duty_err !== (duty_t[i] & DUTY_ON)) begin
        errors++;
        $display("FAIL tol_flags[%0d]: got perr=%b duty=%b want %b/%b",
                 i, period_err, duty_err, perr_t[i], duty_t[i] & DUTY_ON);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mon_periods(5, 5, 3);
    mon_clk = 1'b1;
    tick(5);
    mon_clk = 1'b0;
    tick(60);
    checks++;
    if (stopped !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got stop=%b run=%b want 0/1", stopped, running);
    end
    tick(10);
    checks++;
    if (stopped !== 1'b1 || running !== 1'b0 || dbg.state !== WAIT_RISE) begin
      errors++;
      $display("FAIL timeout_hit: got stop=%b run=%b st=%0d want 1/0/%0d",
               stopped, running, dbg.state, WAIT_RISE);
    end
    mon_clk = 1'b1;
    tick(5);
    checks++;
    if (stopped !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart_rise: got stop=%b run=%b want 0/0", stopped, running);
    end
    mon_clk = 1'b0;
    tick(5);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart_partial: got run=%b want 0", running);
    end
    mon_clk = 1'b1;
    tick(5);
    checks++;
    if (running !== 1'b1 || high_ticks !== 16'd5 || low_ticks !== 16'd5) begin
      errors++;
      $display("FAIL timeout_restart_full: got run=%b %0d/%0d want 1 5/5",
               running, high_ticks, low_ticks);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    mon_periods(5, 5, 2);
    mon_clk = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n   = 1'b1;
    mon_clk = 1'b0;
    checks++;
    if ({high_ticks, low_ticks} !== 32'd0 ||
        {period_valid, period_err, duty_err, running, stopped} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %0d/%0d flags=%b want 0/0 00000", high_ticks, low_ticks,
               {period_valid, period_err, duty_err, running, stopped});
    end
    base = pv_count;
    tick(4);
    mon_periods(4, 6, 2);
    mon_clk = 1'b1;
    tick(5);
    checks++;
    if (pv_count - base !== 2 || high_ticks !== 16'd4 || low_ticks !== 16'd6) begin
      errors++;
      $display("FAIL rstmid_result: got n=%0d %0d/%0d want n=2 4/6",
               pv_count - base, high_ticks, low_ticks);
    end
  endtask

  task automatic test_enable_drop();
    int snap;
    do_reset();
    mon_periods(5, 5, 2);
    mon_clk = 1'b1;
    tick(5);
    mon_clk = 1'b0;
    tick(5);
    enable = 1'b0;
    tick(2);
    checks++;
    if (dbg.state !== IDLE || running !== 1'b0 || stopped !== 1'b0) begin
      errors++;
      $display("FAIL endrop_state: got st=%0d run=%b stop=%b want %0d/0/0",
               dbg.state, running, stopped, IDLE);
    end
    checks++;
    if (high_ticks !== 16'd5 || low_ticks !== 16'd5) begin
      errors++;
      $display("FAIL endrop_hold: got %0d/%0d want 5/5", high_ticks, low_ticks);
    end
    snap   = pv_count;
    enable = 1'b1;
    tick(3);
    mon_periods(4, 6, 1);
    checks++;
    if (pv_count !== snap || running !== 1'b0 || high_ticks !== 16'd5) begin
      errors++;
      $display("FAIL endrop_reenable: got n=%0d run=%b hi=%0d want n=%0d run=0 hi=5",
               pv_count, running, high_ticks, snap);
    end
    mon_clk = 1'b1;
    tick(5);
    checks++;
    if (pv_count !== snap + 1 || high_ticks !== 16'd4 || low_ticks !== 16'd6) begin
      errors++;
      $display("FAIL endrop_full: got n=%0d %0d/%0d want n=%0d 4/6",
               pv_count, high_ticks, low_ticks, snap + 1);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    mon_clk = 1'b0;
    test_reset();
    test_nominal();
    test_period_err();
    test_duty();
    test_tolerance();
    test_timeout();
    test_reset_mid();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
